pma_region_unit: RTL and testbench
==================================

// Module: pma_region_unit
// PURPOSE
//  Runtime-programmable physical-memory-attribute unit that generalises the fixed execute/cached/non-idempotent
//  region tables in the core config package into NrRules lockable registers with NrPorts pipelined lookup channels.
//  Sits beside the MMU/PMP path; fetch and LSU issue physical addresses and get back attributes one cycle later.
//  Reset contents come from parameters, so existing static configs (e.g. DRAM/BootROM/DM) map directly onto it.
// PARAMETERS
//  NrRules      8                     number of region rules, 1..16
//  NrPorts      2                     independent lookup channels (fetch, LSU, ...)
//  AddrWidth    64                    physical address width
//  RstBase      '0                    [NrRules][AddrWidth] reset base per rule
//  RstLength    '0                    [NrRules][AddrWidth] reset length per rule; length 0 = rule disabled
//  RstAttr      '0                    [NrRules] pma_attr_t reset attributes
//  DefaultAttr  '{nonidem:1,default:0} attributes returned when no rule matches
// PORTS
//  clk_i           in   1                     clock
//  rst_i           in   1                     synchronous, active-high reset
//  cfg_we_i        in   1                     rule-field write strobe
//  cfg_idx_i       in   $clog2(NrRules)       rule index (must be 4 bits wide when NrRules=16)
//  cfg_field_i     in   2                     pma_field_e: BASE=0, LENGTH=1, ATTR=2, LOCK=3
//  cfg_wdata_i     in   AddrWidth             write data; ATTR uses [2:0], LOCK uses [0]
//  cfg_err_o       out  1                     1-cycle pulse: write rejected (locked rule or index >= NrRules)
//  req_valid_i     in   NrPorts               lookup request valid
//  req_ready_o     out  NrPorts               lookup request ready
//  req_addr_i      in   NrPorts x AddrWidth   lookup address
//  rsp_valid_o     out  NrPorts               response valid
//  rsp_ready_i     in   NrPorts               response ready
//  rsp_hit_o       out  NrPorts               some enabled rule matched
//  rsp_rule_o      out  NrPorts x $clog2(NrRules)  winning rule index (0 on miss)
//  rsp_attr_o      out  NrPorts x 3           {exec, cached, nonidem}
//  miss_cnt_o      out  NrPorts x 32          saturating count of accepted lookups that missed
// BEHAVIOUR
//  Reset: rules <= RstBase/RstLength/RstAttr, all lock bits 0; rsp_valid_o=0, rsp_hit_o=0, rsp_rule_o=0,
//   rsp_attr_o=0, miss_cnt_o=0, cfg_err_o=0. req_ready_o is 1 from the first cycle after reset.
//  Match: rule i matches iff length_i != 0 and base_i <= addr < base_i+length_i, computed on AddrWidth+1 bits;
//   end clamps to 2^AddrWidth, so an overflowing rule covers [base, top] and never wraps to 0.
//  Priority: lowest-indexed matching rule wins; miss -> hit=0, rule=0, attr=DefaultAttr.
//  Pipeline (per port, independent): one output register stage, latency exactly 1 cycle.
//   req_ready_o[p] = !rsp_valid_o[p] || rsp_ready_i[p] (combinational; no req_valid -> req_ready path).
//   Accept when valid&ready: register hit/rule/attr, set rsp_valid; else if rsp_ready clear rsp_valid.
//   Response fields hold stable while rsp_valid & !rsp_ready. Full throughput: 1 lookup/cycle/port.
//  Config write: takes effect at the next clock edge. A lookup accepted in the same cycle sees the OLD rule.
//   Rejected if lock_i=1 or idx >= NrRules: state unchanged, cfg_err_o=1 on the next cycle.
//   LOCK write of 1 sets lock_i (sticky until reset); LOCK write of 0 on an unlocked rule is a no-op, not an error.
//  miss_cnt_o[p]: +1 per accepted missing lookup; saturates at 32'hFFFF_FFFF.
//  Reset mid-operation: in-flight responses are dropped (rsp_valid=0); programmed rules and locks revert.
// STRUCTURE
//  pma_pkg: pma_attr_t packed struct {exec, cached, nonidem}; pma_field_e enum; pma_rule_t {base, length, attr, lock}.
//  Sub-module pma_rule_match (combinational, one rule vs one address -> match bit), instantiated NrRules x NrPorts;
//   priority select and per-port pipeline register live in this top.
// TESTING
//  Reset with RstBase{0x8000_0000,0x1_0000}, RstLength{0x4000_0000,0x1_0000}; lookup 0x8000_0000 -> next cycle hit=1, rule=0.
//  Boundaries: addr 0xBFFF_FFFF -> hit, rule 0; 0xC000_0000 -> miss, attr=DefaultAttr, miss_cnt +1.
//  Overlap: rules 0 and 1 both cover 0x1_0000, different attrs -> rule=0 with rule-0 attrs; disable rule 0 (length 0) -> rule=1.
//  Lock: LOCK rule 2, then BASE write to rule 2 -> cfg_err_o pulses 1 cycle, lookups unchanged; write idx=NrRules -> err.
//  Backpressure: rsp_ready=0 for 3 cycles with valid held -> req_ready=0, response stable; 4-back-to-back lookups at full rate.
//  Overflow: base=0xFFFF_FFFF_FFFF_F000, length=0x2000 -> addr 0xFFFF_FFFF_FFFF_FFFF hits, addr 0x0 misses.

Source files
------------

// File: rtl/pma_pkg.sv
// Shared types for the physical-memory-attribute region unit.
package pma_pkg;

    typedef struct packed {
        logic exec;
        logic cached;
        logic nonidem;
    } pma_attr_t;

    typedef enum logic [1:0] {
        PMA_BASE   = 2'd0,
        PMA_LENGTH = 2'd1,
        PMA_ATTR   = 2'd2,
        PMA_LOCK   = 2'd3
    } pma_field_e;

    typedef struct packed {
        logic [63:0] base;
        logic [63:0] length;
        pma_attr_t   attr;
        logic        lock;
    } pma_rule_t;

    localparam pma_attr_t PmaDefaultAttr = '{exec: 1'b0, cached: 1'b0, nonidem: 1'b1};

    // Index width that stays legal for a single-rule configuration.
    function automatic int unsigned pma_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pma_rule_match.sv
// One region rule against one address, combinational.
// Compare is done one bit wider than the address so a region running past the top never wraps to 0.
module pma_rule_match #(
    parameter int unsigned AddrWidth = 64
) (
    input  logic [AddrWidth-1:0] base,
    input  logic [AddrWidth-1:0] length,
    input  logic [AddrWidth-1:0] addr,
    output logic                 match
);

    logic [AddrWidth:0] lo;
    logic [AddrWidth:0] hi;
    logic [AddrWidth:0] a;

    always_comb begin
        lo    = {1'b0, base};
        hi    = {1'b0, base} + {1'b0, length};
        a     = {1'b0, addr};
        match = (length != '0) && (a >= lo) && (a < hi);
    end

endmodule

// File: rtl/pma_region_unit.sv
// Programmable PMA region table with NrPorts lookup channels; lookup latency 1 cycle.
// Each port has one output register; req_ready drops only while a response is held by rsp_ready=0.
module pma_region_unit
    import pma_pkg::*;
#(
    parameter int unsigned                         NrRules     = 8,
    parameter int unsigned                         NrPorts     = 2,
    parameter int unsigned                         AddrWidth   = 64,
    parameter logic [NrRules-1:0][AddrWidth-1:0]   RstBase     = '0,
    parameter logic [NrRules-1:0][AddrWidth-1:0]   RstLength   = '0,
    parameter pma_attr_t [NrRules-1:0]             RstAttr     = '0,
    parameter pma_attr_t                           DefaultAttr = PmaDefaultAttr,
    localparam int unsigned                        IdxW        = pma_idx_w(NrRules)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              cfg_we_i,
    input  logic [IdxW-1:0]                   cfg_idx_i,
    input  logic [1:0]                        cfg_field_i,
    input  logic [AddrWidth-1:0]              cfg_wdata_i,
    output logic                              cfg_err_o,
    input  logic [NrPorts-1:0]                req_valid_i,
    output logic [NrPorts-1:0]                req_ready_o,
    input  logic [NrPorts-1:0][AddrWidth-1:0] req_addr_i,
    output logic [NrPorts-1:0]                rsp_valid_o,
    input  logic [NrPorts-1:0]                rsp_ready_i,
    output logic [NrPorts-1:0]                rsp_hit_o,
    output logic [NrPorts-1:0][IdxW-1:0]      rsp_rule_o,
    output logic [NrPorts-1:0][2:0]           rsp_attr_o,
    output logic [NrPorts-1:0][31:0]          miss_cnt_o
);

    logic [AddrWidth-1:0] base_q   [NrRules];
    logic [AddrWidth-1:0] length_q [NrRules];
    pma_attr_t            attr_q   [NrRules];
    logic [NrRules-1:0]   lock_q;

    logic [NrRules-1:0]   match    [NrPorts];
    logic [NrPorts-1:0]   sel_hit;
    logic [IdxW-1:0]      sel_rule [NrPorts];
    pma_attr_t            sel_attr [NrPorts];

    logic                 idx_ok;
    logic                 idx_locked;
    logic                 cfg_reject;

    for (genvar p = 0; p < NrPorts; p++) begin : g_port
        for (genvar r = 0; r < NrRules; r++) begin : g_rule
            pma_rule_match #(.AddrWidth(AddrWidth)) u_match (
                .base   (base_q[r]),
                .length (length_q[r]),
                .addr   (req_addr_i[p]),
                .match  (match[p][r])
            );
        end
    end

    // Scan from the top so the lowest-indexed matching rule is the last writer.
    always_comb begin
        for (int p = 0; p < int'(NrPorts); p++) begin
            sel_hit[p]  = 1'b0;
            sel_rule[p] = '0;
            sel_attr[p] = DefaultAttr;
            for (int r = int'(NrRules) - 1; r >= 0; r--) begin
                if (match[p][r]) begin
                    sel_hit[p]  = 1'b1;
                    sel_rule[p] = IdxW'(r);
                    sel_attr[p] = attr_q[r];
                end
            end
        end
    end

    always_comb begin
        idx_locked = 1'b0;
        for (int r = 0; r < int'(NrRules); r++) begin
            if (cfg_idx_i == IdxW'(r)) idx_locked = lock_q[r];
        end
        idx_ok     = 32'(cfg_idx_i) < NrRules;
        cfg_reject = cfg_we_i && (!idx_ok || idx_locked);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < int'(NrRules); r++) begin
                base_q[r]   <= RstBase[r];
                length_q[r] <= RstLength[r];
                attr_q[r]   <= RstAttr[r];
            end
            lock_q    <= '0;
            cfg_err_o <= 1'b0;
        end else begin
            cfg_err_o <= cfg_reject;
            if (cfg_we_i && !cfg_reject) begin
                for (int r = 0; r < int'(NrRules); r++) begin
                    if (cfg_idx_i == IdxW'(r)) begin
                        case (pma_field_e'(cfg_field_i))
                            PMA_BASE:   base_q[r]   <= cfg_wdata_i;
                            PMA_LENGTH: length_q[r] <= cfg_wdata_i;
                            PMA_ATTR:   attr_q[r]   <= cfg_wdata_i[2:0];
                            PMA_LOCK:   if (cfg_wdata_i[0]) lock_q[r] <= 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign req_ready_o = ~rsp_valid_o | rsp_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_o <= '0;
            rsp_hit_o   <= '0;
            rsp_rule_o  <= '0;
            rsp_attr_o  <= '0;
            miss_cnt_o  <= '0;
        end else begin
            for (int p = 0; p < int'(NrPorts); p++) begin
                if (req_valid_i[p] && req_ready_o[p]) begin
                    rsp_valid_o[p] <= 1'b1;
                    rsp_hit_o[p]   <= sel_hit[p];
                    rsp_rule_o[p]  <= sel_rule[p];
                    rsp_attr_o[p]  <= sel_attr[p];
                    if (!sel_hit[p] && miss_cnt_o[p] != 32'hFFFF_FFFF) begin
                        miss_cnt_o[p] <= miss_cnt_o[p] + 32'd1;
                    end
                end else if (rsp_ready_i[p]) begin
                    rsp_valid_o[p] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pma_region_unit.sv
// Bench for pma_region_unit: directed boundary cases with literal expectations, then random traffic
// checked every cycle against a region-table model.
module tb_pma_region_unit;

    localparam int NR = 6;
    localparam int NP = 2;

    localparam logic [NR-1:0][63:0] RB = {256'h0, 64'h0000_0000_0001_0000, 64'h0000_0000_8000_0000};
    localparam logic [NR-1:0][63:0] RL = {256'h0, 64'h0000_0000_0001_0000, 64'h0000_0000_4000_0000};
    localparam logic [3*NR-1:0]     RA = 18'b000_000_000_000_001_110;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cfg_we;
    logic [2:0]            cfg_idx;
    logic [1:0]            cfg_field;
    logic [63:0]           cfg_wdata;
    logic                  cfg_err;
    logic [NP-1:0]         req_valid;
    logic [NP-1:0]         req_ready;
    logic [NP-1:0][63:0]   req_addr;
    logic [NP-1:0]         rsp_valid;
    logic [NP-1:0]         rsp_ready;
    logic [NP-1:0]         rsp_hit;
    logic [NP-1:0][2:0]    rsp_rule;
    logic [NP-1:0][2:0]    rsp_attr;
    logic [NP-1:0][31:0]   miss_cnt;

    pma_region_unit #(
        .NrRules   (NR),
        .NrPorts   (NP),
        .AddrWidth (64),
        .RstBase   (RB),
        .RstLength (RL),
        .RstAttr   (RA)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_we_i    (cfg_we),
        .cfg_idx_i   (cfg_idx),
        .cfg_field_i (cfg_field),
        .cfg_wdata_i (cfg_wdata),
        .cfg_err_o   (cfg_err),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_hit_o   (rsp_hit),
        .rsp_rule_o  (rsp_rule),
        .rsp_attr_o  (rsp_attr),
        .miss_cnt_o  (miss_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int p, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s port%0d @%0t: got %h want %h", name, p, $time, act, exp);
        end
    endtask

    // Region-table model: rules as plain arrays, responses as per-port "what the register should hold".
    logic [63:0] m_base [NR];
    logic [63:0] m_len  [NR];
    logic [2:0]  m_attr [NR];
    logic        m_lock [NR];
    logic        e_vld  [NP];
    logic        e_hit  [NP];
    logic [2:0]  e_rule [NP];
    logic [2:0]  e_attr [NP];
    logic [31:0] e_miss [NP];
    logic        e_err;
    logic        armed = 1'b0;
    logic        mh;
    logic [2:0]  mr, ma;

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_base[i] = 64'h0; m_len[i] = 64'h0; m_attr[i] = 3'b000; m_lock[i] = 1'b0;
        end
        m_base[0] = 64'h8000_0000; m_len[0] = 64'h4000_0000; m_attr[0] = 3'b110;
        m_base[1] = 64'h1_0000;    m_len[1] = 64'h1_0000;    m_attr[1] = 3'b001;
        for (int p = 0; p < NP; p++) begin
            e_vld[p] = 1'b0; e_hit[p] = 1'b0; e_rule[p] = 3'd0; e_attr[p] = 3'd0; e_miss[p] = 32'd0;
        end
        e_err = 1'b0;
    endtask

    task automatic lookup_model(input logic [63:0] a, output logic hit, output logic [2:0] rule,
                                output logic [2:0] attr);
        hit = 1'b0; rule = 3'd0; attr = 3'b001;
        for (int i = 0; i < NR; i++) begin
            if (!hit && m_len[i] != 64'h0 && a >= m_base[i] && (a - m_base[i]) < m_len[i]) begin
                hit = 1'b1; rule = i[2:0]; attr = m_attr[i];
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
            armed = 1'b1;
        end else if (armed) begin
            for (int p = 0; p < NP; p++) begin
                if (req_valid[p] && (!e_vld[p] || rsp_ready[p])) begin
                    lookup_model(req_addr[p], mh, mr, ma);
                    e_vld[p] = 1'b1; e_hit[p] = mh; e_rule[p] = mr; e_attr[p] = ma;
                    if (!mh && e_miss[p] != 32'hFFFF_FFFF) e_miss[p] = e_miss[p] + 1;
                end else if (rsp_ready[p]) begin
                    e_vld[p] = 1'b0;
                end
            end
            e_err = 1'b0;
            if (cfg_we) begin
                if (cfg_idx >= 3'(NR)) e_err = 1'b1;
                else if (m_lock[cfg_idx]) e_err = 1'b1;
                else begin
                    case (cfg_field)
                        2'd0: m_base[cfg_idx] = cfg_wdata;
                        2'd1: m_len[cfg_idx]  = cfg_wdata;
                        2'd2: m_attr[cfg_idx] = cfg_wdata[2:0];
                        default: if (cfg_wdata[0]) m_lock[cfg_idx] = 1'b1;
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("cfg_err", 0, cfg_err, e_err);
            for (int p = 0; p < NP; p++) begin
                chk("rsp_valid", p, rsp_valid[p], e_vld[p]);
                chk("req_ready", p, req_ready[p], !e_vld[p] || rsp_ready[p]);
                chk("rsp_hit", p, rsp_hit[p], e_hit[p]);
                chk("rsp_rule", p, rsp_rule[p], e_rule[p]);
                chk("rsp_attr", p, rsp_attr[p], e_attr[p]);
                chk("miss_cnt", p, miss_cnt[p], e_miss[p]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [2:0] idx, input logic [1:0] f, input logic [63:0] d);
        cfg_we = 1'b1; cfg_idx = idx; cfg_field = f; cfg_wdata = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic look(input int p, input logic [63:0] a);
        req_valid[p] = 1'b1; req_addr[p] = a;
        step();
        req_valid[p] = 1'b0;
    endtask

    function automatic logic [63:0] pick_addr();
        int i = $urandom_range(0, NR - 1);
        case ($urandom_range(0, 4))
            0:       return m_base[i];
            1:       return m_base[i] + m_len[i] - 64'd1;
            2:       return m_base[i] + m_len[i];
            3:       return m_base[i] - 64'd1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    logic [63:0] b2b_addr [4];
    logic [2:0]  b2b_rule [4];
    logic        b2b_hit  [4];

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_idx = 3'd0; cfg_field = 2'd0; cfg_wdata = 64'h0;
        req_valid = '0; req_addr = '0; rsp_ready = '1;
        step(); step(); step();
        chk("lit_rst_valid", 0, rsp_valid, 2'b00);
        chk("lit_rst_miss", 0, miss_cnt[0], 32'd0);
        chk("lit_rst_fields", 0, {rsp_hit, rsp_rule, rsp_attr}, 14'd0);
        chk("lit_rst_err", 0, cfg_err, 1'b0);
        rst = 1'b0;
        step();
        chk("lit_ready_after_rst", 0, req_ready, 2'b11);

        look(0, 64'h8000_0000);
        chk("lit_hit_base", 0, {rsp_valid[0], rsp_hit[0], rsp_rule[0], rsp_attr[0]}, {2'b11, 3'd0, 3'b110});
        look(0, 64'hBFFF_FFFF);
        chk("lit_hit_last", 0, {rsp_hit[0], rsp_rule[0]}, {1'b1, 3'd0});
        look(0, 64'hC000_0000);
        chk("lit_miss_end", 0, {rsp_hit[0], rsp_rule[0], rsp_attr[0]}, {1'b0, 3'd0, 3'b001});
        chk("lit_miss_cnt", 0, miss_cnt[0], 32'd1);

        do_cfg(3'd0, 2'd0, 64'h0);
        do_cfg(3'd0, 2'd1, 64'h2_0000);
        do_cfg(3'd1, 2'd2, 64'h3);
        look(1, 64'h1_0000);
        chk("lit_overlap_r0", 1, {rsp_hit[1], rsp_rule[1], rsp_attr[1]}, {1'b1, 3'd0, 3'b110});
        do_cfg(3'd0, 2'd1, 64'h0);
        look(1, 64'h1_0000);
        chk("lit_overlap_r1", 1, {rsp_hit[1], rsp_rule[1], rsp_attr[1]}, {1'b1, 3'd1, 3'b011});
        cfg_we = 1'b1; cfg_idx = 3'd1; cfg_field = 2'd1; cfg_wdata = 64'h0;
        look(1, 64'h1_0000);
        cfg_we = 1'b0;
        chk("lit_same_cycle_old_rule", 1, {rsp_hit[1], rsp_rule[1]}, {1'b1, 3'd1});
        look(1, 64'h1_0000);
        chk("lit_after_disable", 1, rsp_hit[1], 1'b0);
        do_cfg(3'd1, 2'd1, 64'h1_0000);

        do_cfg(3'd2, 2'd0, 64'h5000);
        do_cfg(3'd2, 2'd1, 64'h100);
        do_cfg(3'd2, 2'd2, 64'h4);
        do_cfg(3'd2, 2'd3, 64'h1);
        chk("lit_lock_ok", 0, cfg_err, 1'b0);
        do_cfg(3'd2, 2'd0, 64'h9000);
        chk("lit_locked_err", 0, cfg_err, 1'b1);
        step();
        chk("lit_err_pulse", 0, cfg_err, 1'b0);
        look(0, 64'h5000);
        chk("lit_locked_unchanged", 0, {rsp_hit[0], rsp_rule[0], rsp_attr[0]}, {1'b1, 3'd2, 3'b100});
        do_cfg(3'd6, 2'd0, 64'h1234);
        chk("lit_idx_oob_err", 0, cfg_err, 1'b1);
        do_cfg(3'd3, 2'd3, 64'h0);
        chk("lit_lock0_noerr", 0, cfg_err, 1'b0);

        rsp_ready[1] = 1'b0;
        req_valid[1] = 1'b1; req_addr[1] = 64'h5010;
        step();
        req_addr[1] = 64'h8000_0000;
        for (int k = 0; k < 3; k++) begin
            chk("lit_bp_ready", 1, req_ready[1], 1'b0);
            chk("lit_bp_hold", 1, {rsp_valid[1], rsp_rule[1], rsp_attr[1]}, {1'b1, 3'd2, 3'b100});
            step();
        end
        rsp_ready[1] = 1'b1;
        #1;
        chk("lit_bp_release", 1, req_ready[1], 1'b1);
        step();
        req_valid[1] = 1'b0;
        chk("lit_bp_next", 1, {rsp_valid[1], rsp_hit[1], rsp_attr[1]}, {2'b10, 3'b001});

        b2b_addr[0] = 64'h1_0000;   b2b_rule[0] = 3'd1; b2b_hit[0] = 1'b1;
        b2b_addr[1] = 64'h50FF;     b2b_rule[1] = 3'd2; b2b_hit[1] = 1'b1;
        b2b_addr[2] = 64'h5100;     b2b_rule[2] = 3'd0; b2b_hit[2] = 1'b0;
        b2b_addr[3] = 64'h1_FFFF;   b2b_rule[3] = 3'd1; b2b_hit[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_valid[0] = 1'b1; req_addr[0] = b2b_addr[k];
            step();
            chk("lit_b2b", k, {rsp_valid[0], rsp_hit[0], rsp_rule[0]}, {1'b1, b2b_hit[k], b2b_rule[k]});
        end
        req_valid[0] = 1'b0;

        do_cfg(3'd3, 2'd0, 64'hFFFF_FFFF_FFFF_F000);
        do_cfg(3'd3, 2'd1, 64'h2000);
        look(0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("lit_ovf_top", 0, {rsp_hit[0], rsp_rule[0]}, {1'b1, 3'd3});
        look(0, 64'h0);
        chk("lit_ovf_nowrap", 0, rsp_hit[0], 1'b0);

        for (int c = 0; c < 3000; c++) begin
            req_valid = NP'($urandom);
            for (int p = 0; p < NP; p++) begin
                rsp_ready[p] = ($urandom_range(0, 3) != 0);
                req_addr[p]  = pick_addr();
            end
            cfg_we = ($urandom_range(0, 7) == 0);
            cfg_idx = 3'($urandom_range(0, 7));
            cfg_field = 2'($urandom);
            if (cfg_field == 2'd3 && $urandom_range(0, 7) != 0) cfg_field = 2'd2;
            case ($urandom_range(0, 2))
                0:       cfg_wdata = {$urandom, $urandom};
                1:       cfg_wdata = 64'($urandom_range(0, 32'h2_0000));
                default: cfg_wdata = {32'hFFFF_FFFF, $urandom};
            endcase
            step();
        end
        cfg_we = 1'b0;

        req_valid = 2'b11; req_addr[0] = 64'h1_0000; req_addr[1] = 64'h0; rsp_ready = 2'b00;
        step();
        rst = 1'b1;
        step();
        chk("lit_midrst_drop", 0, rsp_valid, 2'b00);
        chk("lit_midrst_cnt", 1, miss_cnt[1], 32'd0);
        rst = 1'b0; req_valid = '0; rsp_ready = '1;
        step();
        look(0, 64'h8000_0000);
        chk("lit_midrst_revert", 0, {rsp_hit[0], rsp_rule[0], rsp_attr[0]}, {1'b1, 3'd0, 3'b110});
        do_cfg(3'd2, 2'd0, 64'h9000);
        chk("lit_midrst_unlock", 0, cfg_err, 1'b0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
